// File: rtl/datapath_reg_bank_pkg.sv
// Shared constants for the datapath register bank and the control unit that drives it.
// Register indices, bus select codes and enable-vector width live here.
package datapath_reg_bank_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int EN_W       = 16;

  typedef logic [3:0] bus_sel_t;

  localparam bus_sel_t BUS_SEL_MEM = 4'hF;

  // Register map seen by the control unit.
  localparam int REG_AR = 0;
  localparam int REG_PC = 1;
  localparam int REG_IR = 2;
  localparam int REG_AC = 3;
  localparam int REG_Z1 = 4;
  localparam int REG_Z2 = 5;
  localparam int REG_T0 = 6;
  localparam int REG_T1 = 7;

endpackage

// File: rtl/datapath_reg_bank_dp_register.sv
// Single datapath register: async active-low clear, then synchronous clear,
// load and increment in that priority order.
module dp_register #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wrt,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (wrt) q <= d;
    else if (inc) q <= q + W'(1);
  end

endmodule

// File: rtl/datapath_reg_bank.sv
// Register bank with shared bus multiplexer; returns INS and the two zero flags.
// No handshake: one enable vector is consumed every clock, sequencing is owned by the control unit.
module datapath_reg_bank
  import datapath_reg_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_REG  = 15,
  parameter int IR_IDX = REG_IR,
  parameter int AC_IDX = REG_AC,
  parameter int Z1_IDX = REG_Z1,
  parameter int Z2_IDX = REG_Z2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        Bus_Ctrl,
  input  logic [EN_W-1:0]   WRT_en,
  input  logic [EN_W-1:0]   INC_en,
  input  logic [EN_W-1:0]   RST_en,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] ac_out,
  output logic [7:0]        INS,
  output logic              Z1,
  output logic              Z2
);

  logic [DATA_W-1:0] regs [N_REG];

  // Enable bits beyond the last register have no destination.
  logic unused_en;
  assign unused_en = ^{WRT_en[EN_W-1:N_REG], INC_en[EN_W-1:N_REG], RST_en[EN_W-1:N_REG]};

  always_comb begin
    bus_out = '0;
    if (Bus_Ctrl == BUS_SEL_MEM) begin
      bus_out = mem_rdata;
    end else begin
      for (int i = 0; i < N_REG; i++) begin
        if (Bus_Ctrl == 4'(i)) bus_out = regs[i];
      end
    end
  end

  for (genvar g = 0; g < N_REG; g++) begin : g_reg
    logic [DATA_W-1:0] load_d;
    // The accumulator is the only register fed from the ALU rather than the bus.
    if (g == AC_IDX) begin : g_ac
      assign load_d = alu_result;
    end else begin : g_bus
      assign load_d = bus_out;
    end

    dp_register #(.W(DATA_W)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (RST_en[g]),
      .wrt   (WRT_en[g]),
      .inc   (INC_en[g]),
      .d     (load_d),
      .q     (regs[g])
    );
  end

  assign ac_out = regs[AC_IDX];
  assign INS    = regs[IR_IDX][7:0];
  assign Z1     = (regs[Z1_IDX] == '0);
  assign Z2     = (regs[Z2_IDX] == '0);

endmodule

// File: tb/tb_datapath_reg_bank.sv
// Directed bench for datapath_reg_bank: reset, bus loads, priority, wrap, AC source,
// self-write, ignored enables and same-cycle multi-register traffic.
module tb_datapath_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  Bus_Ctrl;
  logic [15:0] WRT_en;
  logic [15:0] INC_en;
  logic [15:0] RST_en;
  logic [15:0] alu_result;
  logic [15:0] mem_rdata;
  logic [15:0] bus_out;
  logic [15:0] ac_out;
  logic [7:0]  INS;
  logic        Z1;
  logic        Z2;

  int n_checks = 0;
  int n_fail   = 0;

  datapath_reg_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Bus_Ctrl   (Bus_Ctrl),
    .WRT_en     (WRT_en),
    .INC_en     (INC_en),
    .RST_en     (RST_en),
    .alu_result (alu_result),
    .mem_rdata  (mem_rdata),
    .bus_out    (bus_out),
    .ac_out     (ac_out),
    .INS        (INS),
    .Z1         (Z1),
    .Z2         (Z2)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WRT_en = '0;
    INC_en = '0;
    RST_en = '0;
  endtask

  task automatic load_reg(input int idx, input logic [15:0] val);
    mem_rdata  = val;
    alu_result = val;
    Bus_Ctrl   = 4'hF;
    idle();
    WRT_en[idx] = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Bus_Ctrl = 4'h0;
    mem_rdata = 16'h0;
    alu_result = 16'h0;
    idle();
    #2;
    n_checks++; if (INS !== 8'h00) begin n_fail++; $display("FAIL reset_ins: got %h want 00", INS); end
    n_checks++; if (ac_out !== 16'h0) begin n_fail++; $display("FAIL reset_ac: got %h want 0000", ac_out); end
    n_checks++; if (Z1 !== 1'b1 || Z2 !== 1'b1) begin n_fail++; $display("FAIL reset_flags: got Z1=%b Z2=%b want 1 1", Z1, Z2); end
    n_checks++; if (bus_out !== 16'h0) begin n_fail++; $display("FAIL reset_bus: got %h want 0000", bus_out); end
    tick();
    rst_n = 1'b1;
    tick();
    load_reg(4, 16'h0005);
    load_reg(2, 16'h005A);
    load_reg(5, 16'h0003);
    Bus_Ctrl = 4'd4;
    #1;
    n_checks++; if (bus_out !== 16'h0005 || Z1 !== 1'b0) begin n_fail++; $display("FAIL pre_reset_reg4: got %h Z1=%b want 0005 Z1=0", bus_out, Z1); end
    n_checks++; if (INS !== 8'h5A) begin n_fail++; $display("FAIL pre_reset_ins: got %h want 5a", INS); end
    // Async reset mid-cycle, no clock edge in between.
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus_out !== 16'h0) begin n_fail++; $display("FAIL async_reset_reg4: got %h want 0000", bus_out); end
    n_checks++; if (Z1 !== 1'b1 || Z2 !== 1'b1 || INS !== 8'h00) begin n_fail++; $display("FAIL async_reset_outs: got Z1=%b Z2=%b INS=%h want 1 1 00", Z1, Z2, INS); end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bus_load();
    mem_rdata = 16'h00A7;
    Bus_Ctrl  = 4'hF;
    idle();
    #1;
    n_checks++; if (bus_out !== 16'h00A7) begin n_fail++; $display("FAIL bus_mem_sel: got %h want 00a7", bus_out); end
    WRT_en[2] = 1'b1;
    tick();
    idle();
    n_checks++; if (INS !== 8'hA7) begin n_fail++; $display("FAIL bus_load_ins: got %h want a7", INS); end
    Bus_Ctrl = 4'd2;
    WRT_en[0] = 1'b1;
    tick();
    idle();
    Bus_Ctrl = 4'd0;
    #1;
    n_checks++; if (bus_out !== 16'h00A7) begin n_fail++; $display("FAIL bus_copy_reg0: got %h want 00a7", bus_out); end
  endtask

  task automatic test_priority();
    load_reg(5, 16'h1234);
    n_checks++; if (Z2 !== 1'b0) begin n_fail++; $display("FAIL prio_z2_nonzero: got %b want 0", Z2); end
    RST_en[5] = 1'b1; WRT_en[5] = 1'b1; INC_en[5] = 1'b1;
    tick();
    idle();
    Bus_Ctrl = 4'd5;
    #1;
    n_checks++; if (bus_out !== 16'h0 || Z2 !== 1'b1) begin n_fail++; $display("FAIL prio_rst_wins: got %h Z2=%b want 0000 Z2=1", bus_out, Z2); end
    mem_rdata = 16'h0010;
    Bus_Ctrl  = 4'hF;
    WRT_en[5] = 1'b1; INC_en[5] = 1'b1;
    tick();
    idle();
    Bus_Ctrl = 4'd5;
    #1;
    n_checks++; if (bus_out !== 16'h0010) begin n_fail++; $display("FAIL prio_wrt_wins: got %h want 0010", bus_out); end
    INC_en[5] = 1'b1;
    tick();
    idle();
    n_checks++; if (bus_out !== 16'h0011) begin n_fail++; $display("FAIL prio_inc_alone: got %h want 0011", bus_out); end
  endtask

  task automatic test_wrap();
    load_reg(4, 16'hFFFE);
    Bus_Ctrl = 4'd4;
    INC_en[4] = 1'b1;
    tick();
    n_checks++; if (bus_out !== 16'hFFFF || Z1 !== 1'b0) begin n_fail++; $display("FAIL wrap_ffff: got %h Z1=%b want ffff Z1=0", bus_out, Z1); end
    tick();
    idle();
    n_checks++; if (bus_out !== 16'h0000 || Z1 !== 1'b1) begin n_fail++; $display("FAIL wrap_zero: got %h Z1=%b want 0000 Z1=1", bus_out, Z1); end
  endtask

  task automatic test_acc_source();
    alu_result = 16'h0F0F;
    mem_rdata  = 16'h1111;
    Bus_Ctrl   = 4'hF;
    WRT_en[3] = 1'b1; WRT_en[6] = 1'b1;
    tick();
    idle();
    Bus_Ctrl = 4'd6;
    #1;
    n_checks++; if (ac_out !== 16'h0F0F) begin n_fail++; $display("FAIL acc_from_alu: got %h want 0f0f", ac_out); end
    n_checks++; if (bus_out !== 16'h1111) begin n_fail++; $display("FAIL acc_reg6_bus: got %h want 1111", bus_out); end
  endtask

  task automatic test_self_write();
    load_reg(7, 16'h0042);
    Bus_Ctrl = 4'd7;
    WRT_en[7] = 1'b1;
    tick();
    idle();
    n_checks++; if (bus_out !== 16'h0042) begin n_fail++; $display("FAIL self_write: got %h want 0042", bus_out); end
    mem_rdata  = 16'hBEEF;
    alu_result = 16'hBEEF;
    Bus_Ctrl   = 4'hF;
    WRT_en = 16'h8000; INC_en = 16'h8000; RST_en = 16'h8000;
    tick();
    idle();
    n_checks++; if (ac_out !== 16'h0F0F) begin n_fail++; $display("FAIL unused_en_ac: got %h want 0f0f", ac_out); end
    Bus_Ctrl = 4'd0;
    #1;
    n_checks++; if (bus_out !== 16'h00A7) begin n_fail++; $display("FAIL unused_en_reg0: got %h want 00a7", bus_out); end
    Bus_Ctrl = 4'd14;
    #1;
    n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL unused_en_reg14: got %h want 0000", bus_out); end
    Bus_Ctrl = 4'd7;
    #1;
    n_checks++; if (bus_out !== 16'h0042) begin n_fail++; $display("FAIL unused_en_reg7: got %h want 0042", bus_out); end
  endtask

  task automatic test_back_to_back();
    mem_rdata = 16'h3C3C;
    Bus_Ctrl  = 4'hF;
    WRT_en[8] = 1'b1; WRT_en[9] = 1'b1;
    tick();
    idle();
    // reg8 increments while reg9 copies reg8's pre-edge value.
    Bus_Ctrl = 4'd8;
    INC_en[8] = 1'b1;
    WRT_en[9] = 1'b1;
    tick();
    idle();
    n_checks++; if (bus_out !== 16'h3C3D) begin n_fail++; $display("FAIL b2b_reg8_inc: got %h want 3c3d", bus_out); end
    Bus_Ctrl = 4'd9;
    #1;
    n_checks++; if (bus_out !== 16'h3C3C) begin n_fail++; $display("FAIL b2b_reg9_old: got %h want 3c3c", bus_out); end
    Bus_Ctrl = 4'd14;
    WRT_en[14] = 1'b1;
    mem_rdata = 16'h7777;
    tick();
    idle();
    n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL b2b_reg14_self: got %h want 0000", bus_out); end
  endtask

  initial begin
    test_reset();
    test_bus_load();
    test_priority();
    test_wrap();
    test_acc_source();
    test_self_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
